// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer: streams an 8-byte Modbus write response or a 5-byte exception frame
// to a byte UART, with a per-byte done timeout and a 3.5-character silence gap after each frame.
module tx_frame_sequencer #(
  parameter int unsigned T35_CYCLES   = 200521,
  parameter int unsigned DONE_TIMEOUT = 1000000
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        tx_start,
  input  logic        frame_sel,
  input  logic [63:0] code06_response,
  input  logic [39:0] exception_seq,
  input  logic        uart_tx_done,
  output logic        uart_tx_en,
  output logic [7:0]  uart_tx_data,
  output logic        tx_busy,
  output logic        frame_done,
  output logic        tx_abort,
  output logic        tx_overrun
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  localparam logic [19:0] GAP_LAST = 20'(T35_CYCLES - 1);
  localparam logic [23:0] TO_LAST  = 24'(DONE_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [63:0] r_shift;
  logic [3:0]  r_byte_cnt;
  logic [23:0] r_to_cnt;
  logic [19:0] r_gap_cnt;
  logic        w_done;
  logic        w_timeout;
  logic        w_last_byte;
  logic        w_gap_end;

  // A done on the threshold cycle wins over the timeout.
  assign w_done      = (r_state == WAIT) && uart_tx_done;
  assign w_timeout   = (r_state == WAIT) && !uart_tx_done && (r_to_cnt == TO_LAST);
  assign w_last_byte = (r_byte_cnt == 4'd1);
  assign w_gap_end   = (r_state == GAP) && (r_gap_cnt >= GAP_LAST);

  // NOTE: sequential state uses <= so every register samples the pre-edge values of the others.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= IDLE;
    else           r_state <= w_next_state;
  end

  // NOTE: next state defaults to the current state first, so no branch can infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (tx_start) w_next_state = SEND;
      SEND: w_next_state = WAIT;
      WAIT: begin
        if (w_done)         w_next_state = w_last_byte ? GAP : SEND;
        else if (w_timeout) w_next_state = GAP;
      end
      GAP:  if (w_gap_end) w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_shift      <= '0;
      r_byte_cnt   <= '0;
      r_to_cnt     <= '0;
      r_gap_cnt    <= '0;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= 8'h00;
      tx_busy      <= 1'b0;
      frame_done   <= 1'b0;
      tx_abort     <= 1'b0;
      tx_overrun   <= 1'b0;
    end else begin
      uart_tx_en <= 1'b0;
      frame_done <= 1'b0;
      tx_abort   <= 1'b0;
      if (tx_start && (r_state != IDLE)) tx_overrun <= 1'b1;

      unique case (r_state)
        IDLE: begin
          if (tx_start) begin
            r_shift    <= frame_sel ? {exception_seq, 24'h000000} : code06_response;
            r_byte_cnt <= frame_sel ? 4'd5 : 4'd8;
            tx_busy    <= 1'b1;
          end
        end
        SEND: begin
          uart_tx_en   <= 1'b1;
          uart_tx_data <= r_shift[63:56];
          r_to_cnt     <= '0;
        end
        WAIT: begin
          if (w_done) begin
            r_shift    <= r_shift << 8;
            r_byte_cnt <= r_byte_cnt - 4'd1;
            if (w_last_byte) begin
              frame_done <= 1'b1;
              // The line went quiet on the done cycle, so it counts as the first silent cycle.
              r_gap_cnt  <= 20'd1;
            end
          end else begin
            r_to_cnt <= r_to_cnt + 24'd1;
            if (w_timeout) begin
              tx_abort   <= 1'b1;
              r_shift    <= '0;
              r_byte_cnt <= '0;
              r_gap_cnt  <= '0;
            end
          end
        end
        GAP: begin
          if (w_gap_end) tx_busy   <= 1'b0;
          else           r_gap_cnt <= r_gap_cnt + 20'd1;
        end
      endcase
    end
  end

endmodule
